fp_add_align: RTL and testbench

FP_ADD_ALIGN -- requirements
Module: fp_add_align

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_add_align_if.sv | 32 +++
 rtl/mant_rshift_sticky.sv | 26 ++
 rtl/fp_add_align.sv | 140 ++++++++++++++
 tb/tb_fp_add_align.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision constants, the unpacked-operand type and the unpack helper
// used by the add-alignment pipeline.
package fp_pkg;

    localparam int FP_EXP_W   = 8;
    localparam int FP_MANT_W  = 24;
    localparam int FP_SHAMT_W = 5;

    localparam logic [FP_EXP_W-1:0]   FP_EXP_SPECIAL = 8'hFF;
    localparam logic [FP_SHAMT_W-1:0] FP_SHAMT_MAX   = 5'd31;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp_unpacked_t;

    // Denormals flush to signed zero; normals get the hidden bit restored.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        if (x[30:23] == 8'd0) begin
            u.exp  = 8'd0;
            u.mant = 24'd0;
        end else begin
            u.exp  = x[30:23];
            u.mant = {1'b1, x[22:0]};
        end
        return u;
    endfunction

    function automatic logic fp_is_special(input logic [31:0] x);
        return (x[30:23] == FP_EXP_SPECIAL);
    endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Operand-in / aligned-result-out valid-ready channels of the FP add alignment stage.
interface fp_add_align_if;
    import fp_pkg::*;

    logic                 in_vld;
    logic                 in_rdy;
    logic [31:0]          a;
    logic [31:0]          b;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 out_sign_big;
    logic                 out_sign_small;
    logic [FP_EXP_W-1:0]  out_exp;
    logic [FP_MANT_W-1:0] out_mant_big;
    logic [FP_MANT_W-1:0] out_mant_small;
    logic                 out_sticky;
    logic                 out_sub;
    logic                 out_special;

    modport slave (
        input  in_vld, a, b, out_rdy,
        output in_rdy, out_vld, out_sign_big, out_sign_small, out_exp,
               out_mant_big, out_mant_small, out_sticky, out_sub, out_special
    );

    modport master (
        output in_vld, a, b, out_rdy,
        input  in_rdy, out_vld, out_sign_big, out_sign_small, out_exp,
               out_mant_big, out_mant_small, out_sticky, out_sub, out_special
    );

endinterface

// File: rtl/mant_rshift_sticky.sv
// Logical right shift of a hidden-bit mantissa with a sticky flag collecting every bit
// shifted out; shifts of 24 or more clear the value and fold the whole mantissa into sticky.
module mant_rshift_sticky
    import fp_pkg::*;
(
    input  logic [FP_MANT_W-1:0]  mant,
    input  logic [FP_SHAMT_W-1:0] shamt,
    output logic [FP_MANT_W-1:0]  shifted,
    output logic                  sticky
);

    logic [FP_MANT_W-1:0] lost_mask_s;

    // Mask of the bit positions that fall off the bottom for this shift amount.
    always_comb begin
        lost_mask_s = 24'd0;
        if (shamt >= 5'd24) begin
            lost_mask_s = {FP_MANT_W{1'b1}};
        end else begin
            lost_mask_s = (24'd1 << shamt) - 24'd1;
        end
        shifted = mant >> shamt;
        sticky  = |(mant & lost_mask_s);
    end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage FP add front end: stage 1 unpacks, orders by magnitude and computes the
// shift; stage 2 aligns the smaller mantissa and produces sticky. Valid-ready on both sides.
module fp_add_align
    import fp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fp_add_align_if.slave bus
);

    fp_unpacked_t          a_u_s;
    fp_unpacked_t          b_u_s;
    fp_unpacked_t          big_s;
    fp_unpacked_t          small_s;
    logic [FP_EXP_W-1:0]   diff_s;
    logic [FP_SHAMT_W-1:0] shamt_s;
    logic                  special_s;
    logic                  in_rdy_s;
    logic                  s1_load_s;
    logic                  s2_adv_s;
    logic [FP_MANT_W-1:0]  shifted_s;
    logic                  sticky_s;

    logic                  s1_vld_r;
    fp_unpacked_t          s1_big_r;
    fp_unpacked_t          s1_small_r;
    logic [FP_SHAMT_W-1:0] s1_shamt_r;
    logic                  s1_special_r;

    logic                  s2_vld_r;
    logic                  s2_sign_big_r;
    logic                  s2_sign_small_r;
    logic [FP_EXP_W-1:0]   s2_exp_r;
    logic [FP_MANT_W-1:0]  s2_mant_big_r;
    logic [FP_MANT_W-1:0]  s2_mant_small_r;
    logic                  s2_sticky_r;
    logic                  s2_sub_r;
    logic                  s2_special_r;

    // Stage 2 refills whenever it is empty or its result leaves this cycle.
    assign s2_adv_s  = s1_vld_r && (!s2_vld_r || bus.out_rdy);
    assign in_rdy_s  = !s1_vld_r || s2_adv_s;
    assign s1_load_s = bus.in_vld && in_rdy_s;

    // Magnitude ordering compares raw {exp, frac}, so a tie keeps a as the big operand.
    always_comb begin
        a_u_s     = fp_unpack(bus.a);
        b_u_s     = fp_unpack(bus.b);
        special_s = fp_is_special(bus.a) || fp_is_special(bus.b);
        if (bus.a[30:0] >= bus.b[30:0]) begin
            big_s   = a_u_s;
            small_s = b_u_s;
        end else begin
            big_s   = b_u_s;
            small_s = a_u_s;
        end
        diff_s = big_s.exp - small_s.exp;
        if (diff_s > 8'd31) begin
            shamt_s = FP_SHAMT_MAX;
        end else begin
            shamt_s = diff_s[FP_SHAMT_W-1:0];
        end
    end

    // Stage occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r <= 1'b0;
            s2_vld_r <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_vld_r <= 1'b1;
            end else if (s2_adv_s) begin
                s1_vld_r <= 1'b0;
            end
            if (s2_adv_s) begin
                s2_vld_r <= 1'b1;
            end else if (bus.out_rdy) begin
                s2_vld_r <= 1'b0;
            end
        end
    end

    // Stage 1 datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_big_r     <= '0;
            s1_small_r   <= '0;
            s1_shamt_r   <= 5'd0;
            s1_special_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_big_r     <= big_s;
            s1_small_r   <= small_s;
            s1_shamt_r   <= shamt_s;
            s1_special_r <= special_s;
        end
    end

    mant_rshift_sticky u_rshift (
        .mant    (s1_small_r.mant),
        .shamt   (s1_shamt_r),
        .shifted (shifted_s),
        .sticky  (sticky_s)
    );

    // Stage 2 result registers; they only change on advance, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign_big_r   <= 1'b0;
            s2_sign_small_r <= 1'b0;
            s2_exp_r        <= 8'd0;
            s2_mant_big_r   <= 24'd0;
            s2_mant_small_r <= 24'd0;
            s2_sticky_r     <= 1'b0;
            s2_sub_r        <= 1'b0;
            s2_special_r    <= 1'b0;
        end else if (s2_adv_s) begin
            s2_sign_big_r   <= s1_big_r.sign;
            s2_sign_small_r <= s1_small_r.sign;
            s2_exp_r        <= s1_big_r.exp;
            s2_mant_big_r   <= s1_big_r.mant;
            s2_mant_small_r <= shifted_s;
            s2_sticky_r     <= sticky_s;
            s2_sub_r        <= s1_big_r.sign ^ s1_small_r.sign;
            s2_special_r    <= s1_special_r;
        end
    end

    assign bus.in_rdy         = in_rdy_s;
    assign bus.out_vld        = s2_vld_r;
    assign bus.out_sign_big   = s2_sign_big_r;
    assign bus.out_sign_small = s2_sign_small_r;
    assign bus.out_exp        = s2_exp_r;
    assign bus.out_mant_big   = s2_mant_big_r;
    assign bus.out_mant_small = s2_mant_small_r;
    assign bus.out_sticky     = s2_sticky_r;
    assign bus.out_sub        = s2_sub_r;
    assign bus.out_special    = s2_special_r;

endmodule

// File: tb/tb_fp_add_align.sv
// Self-checking bench for fp_add_align: directed cases, backpressure, mid-flight reset and
// randomized handshakes scored against an arithmetic reference model.
module tb_fp_add_align;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fp_add_align_if bus ();

    fp_add_align dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sb;
        logic        ss;
        logic [7:0]  e;
        logic [23:0] mb;
        logic [23:0] ms;
        logic        st;
        logic        sub;
        logic        sp;
    } res_t;

    res_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   n_in     = 0;
    int   n_out    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected result straight from the arithmetic definition: divide by 2^d, remainder -> sticky.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        logic [31:0] bg;
        logic [31:0] sm;
        int          eb;
        int          es;
        int          d;
        longint      mb;
        longint      ms;
        longint      p;
        if (x[30:0] >= y[30:0]) begin bg = x; sm = y; end
        else begin bg = y; sm = x; end
        eb = int'(bg[30:23]);
        es = int'(sm[30:23]);
        mb = (eb == 0) ? 64'd0 : (64'd8388608 + longint'(bg[22:0]));
        ms = (es == 0) ? 64'd0 : (64'd8388608 + longint'(sm[22:0]));
        d  = eb - es;
        if (d > 31) d = 31;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 2;
        r.sb  = bg[31];
        r.ss  = sm[31];
        r.e   = 8'(eb);
        r.mb  = 24'(mb);
        r.ms  = 24'(ms / p);
        r.st  = (ms % p) != 0;
        r.sub = bg[31] != sm[31];
        r.sp  = (eb == 255) || (es == 255);
        return r;
    endfunction

    function automatic logic [63:0] out_word();
        return {3'b000, bus.out_sign_big, bus.out_sign_small, bus.out_exp, bus.out_mant_big,
                bus.out_mant_small, bus.out_sticky, bus.out_sub, bus.out_special};
    endfunction

    task automatic check_res(input string tag, input res_t e);
        chk({tag, ".special"}, 64'(bus.out_special), 64'(e.sp));
        if (!e.sp) begin
            chk({tag, ".sign_big"},   64'(bus.out_sign_big),   64'(e.sb));
            chk({tag, ".sign_small"}, 64'(bus.out_sign_small), 64'(e.ss));
            chk({tag, ".exp"},        64'(bus.out_exp),        64'(e.e));
            chk({tag, ".mant_big"},   64'(bus.out_mant_big),   64'(e.mb));
            chk({tag, ".mant_small"}, 64'(bus.out_mant_small), 64'(e.ms));
            chk({tag, ".sticky"},     64'(bus.out_sticky),     64'(e.st));
            chk({tag, ".sub"},        64'(bus.out_sub),        64'(e.sub));
        end
    endtask

    // One cycle at the negedge: drive, score both handshakes, advance to next negedge.
    task automatic cycle(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                         input logic ordy, output logic acc);
        res_t e;
        bus.in_vld  = iv;
        bus.a       = av;
        bus.b       = bv;
        bus.out_rdy = ordy;
        #1;
        acc = iv && bus.in_rdy;
        if (acc) begin
            sbq.push_back(model(av, bv));
            n_in++;
        end
        if (bus.out_vld && ordy) begin
            chk("sb.nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check_res("sb", e);
                n_out++;
            end
        end
        @(negedge clk);
    endtask

    // Single isolated transaction with exact latency check.
    task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv);
        bus.a = av; bus.b = bv; bus.in_vld = 1'b1; bus.out_rdy = 1'b1;
        #1 chk({tag, ".in_rdy"}, 64'(bus.in_rdy), 64'd1);
        @(negedge clk);
        bus.in_vld = 1'b0;
        chk({tag, ".lat1"}, 64'(bus.out_vld), 64'd0);
        @(negedge clk);
        chk({tag, ".lat2"}, 64'(bus.out_vld), 64'd1);
        check_res(tag, model(av, bv));
        @(negedge clk);
        chk({tag, ".drain"}, 64'(bus.out_vld), 64'd0);
    endtask

    task automatic gen_pair(output logic [31:0] av, output logic [31:0] bv);
        int          ea;
        int          eb;
        int          k;
        logic [31:0] t;
        ea = int'($urandom_range(1, 254));
        eb = ea - int'($urandom_range(0, 40));
        if (eb < 1) eb = 1;
        k = int'($urandom_range(0, 19));
        if (k == 0) eb = 0;
        if (k == 1) ea = 255;
        av = {1'($urandom), 8'(ea), 23'($urandom)};
        bv = {1'($urandom), 8'(eb), 23'($urandom)};
        if (k == 2) bv = {~av[31], av[30:0]};
        if ($urandom_range(0, 1) == 1) begin t = av; av = bv; bv = t; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ta[3];
        logic [31:0] tb[3];
        logic [31:0] av;
        logic [31:0] bv;
        logic [63:0] snap;
        logic        have_snap;
        logic        acc;
        int          idx;

        bus.in_vld = 1'b0; bus.out_rdy = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.out_vld", 64'(bus.out_vld), 64'd0);
        chk("reset.in_rdy",  64'(bus.in_rdy),  64'd1);
        chk("reset.data",    out_word(),       64'd0);

        run_one("req034", 32'h40400000, 32'h3F800000);
        run_one("req035", 32'h3F800000, 32'hC0400000);
        run_one("req036a", 32'h4F800000, 32'h3F800001);
        run_one("req036b", 32'h40000000, 32'h3F800001);
        run_one("req038", 32'h7F800000, 32'h3F800000);
        run_one("tie", 32'h3F800000, 32'hBF800000);
        run_one("denorm", 32'h3F800000, 32'h00000123);

        // Backpressure: three offered back to back, output stalled for five cycles.
        for (int i = 0; i < 3; i++) gen_pair(ta[i], tb[i]);
        ta[0] = 32'h40400000; tb[0] = 32'h3F800000;
        idx = 0; have_snap = 1'b0; snap = 64'd0;
        for (int c = 0; c < 5; c++) begin
            cycle(idx < 3, ta[idx % 3], tb[idx % 3], 1'b0, acc);
            if (acc) idx++;
            if (bus.out_vld) begin
                if (!have_snap) begin
                    snap = out_word();
                    have_snap = 1'b1;
                end else begin
                    chk("bp.hold", out_word(), snap);
                end
            end
        end
        chk("bp.accepted", 64'(idx), 64'd2);
        chk("bp.out_vld", 64'(bus.out_vld), 64'd1);
        bus.in_vld = 1'b1; bus.a = ta[2]; bus.b = tb[2];
        #1 chk("bp.in_rdy", 64'(bus.in_rdy), 64'd0);
        for (int c = 0; c < 20 && (idx < 3 || sbq.size() != 0); c++) begin
            cycle(idx < 3, ta[idx % 3], tb[idx % 3], 1'b1, acc);
            if (acc) idx++;
        end
        chk("bp.all_out", 64'(sbq.size()), 64'd0);

        // Randomized handshakes on both sides.
        for (int c = 0; c < 600; c++) begin
            gen_pair(av, bv);
            cycle($urandom_range(0, 3) != 0, av, bv, $urandom_range(0, 3) != 0, acc);
        end
        for (int c = 0; c < 10; c++) cycle(1'b0, 32'd0, 32'd0, 1'b1, acc);
        chk("rand.drained", 64'(sbq.size()), 64'd0);
        chk("rand.in_eq_out", 64'(n_in), 64'(n_out));

        // Reset with two transactions in flight.
        cycle(1'b1, 32'h40400000, 32'h3F800000, 1'b0, acc);
        cycle(1'b1, 32'h40000000, 32'h3F800001, 1'b0, acc);
        chk("rst.inflight", 64'(bus.out_vld), 64'd1);
        bus.in_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.out_vld", 64'(bus.out_vld), 64'd0);
        chk("rst.in_rdy",  64'(bus.in_rdy),  64'd1);
        chk("rst.data",    out_word(),       64'd0);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 chk("rst.stale", 64'(bus.out_vld), 64'd0);
            cycle(1'b0, 32'd0, 32'd0, 1'b1, acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
